// File: rtl/lcd_pkg.sv
// Shared definitions for the character-LCD reader and writer.
// Holds the bus-cycle state encoding, the busy-flag bit position, the RW/RS
// line encodings and a small sizing helper for the phase counters.
package lcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETUP   = 2'd1,
    ST_EN_HIGH = 2'd2,
    ST_EN_LOW  = 2'd3
  } lcd_state_e;

  localparam int unsigned LCD_BF_BIT = 7;

  localparam logic LCD_RW_WRITE = 1'b0;
  localparam logic LCD_RW_READ  = 1'b1;

  localparam logic LCD_RS_CMD  = 1'b0;
  localparam logic LCD_RS_DATA = 1'b1;

  // Largest of three phase lengths; sizes the shared phase counter.
  function automatic int unsigned lcd_max3(input int unsigned a,
                                           input int unsigned b,
                                           input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/lcd_phase_timer.sv
// Loadable down-counter used to time the phases of an LCD bus cycle.
// Ports:
//   clock, reset_n : system clock, synchronous active-low reset
//   load           : load load_value this cycle (overrides counting)
//   load_value     : remaining cycles after the current one (phase length - 1)
//   expired        : counter is zero, i.e. the current cycle ends the phase
// The counter saturates at zero and never wraps.
module lcd_phase_timer #(
  parameter int unsigned WIDTH = 5
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             expired
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_value;
    end else if (count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == '0);

endmodule

// File: rtl/lcd_reader.sv
// HD44780-style read engine. On a rising edge of start (while idle) it runs
// one RW=1 bus cycle (setup, EN high, EN low) and returns the sampled byte.
// In poll mode it reads the BF/AC register repeatedly until BF clears or
// POLL_LIMIT pulses have been issued.
// Ports:
//   clock, reset_n  : system clock, synchronous active-low reset
//   start           : rising edge requests a transaction
//   rs, poll        : register select / busy-poll mode, latched at accept
//   rd_data         : last byte sampled from the bus
//   done, timeout   : completion flag (held) and poll-timeout flag
//   busy            : transaction in progress
//   lcd_data_in     : LCD data bus, input side
//   lcd_rw, lcd_en, lcd_rs : LCD control lines
//   lcd_bus_active  : reader owns the bus (top selects reader control)
module lcd_reader
  import lcd_pkg::*;
#(
  parameter int unsigned SETUP_CYCLES   = 2,
  parameter int unsigned EN_HIGH_CYCLES = 16,
  parameter int unsigned EN_LOW_CYCLES  = 16,
  parameter int unsigned POLL_LIMIT     = 1024
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       start,
  input  logic       rs,
  input  logic       poll,
  output logic [7:0] rd_data,
  output logic       done,
  output logic       timeout,
  output logic       busy,
  input  logic [7:0] lcd_data_in,
  output logic       lcd_rw,
  output logic       lcd_en,
  output logic       lcd_rs,
  output logic       lcd_bus_active
);

  localparam int unsigned PH_MAX = lcd_max3(SETUP_CYCLES, EN_HIGH_CYCLES, EN_LOW_CYCLES);
  localparam int unsigned PHW    = $clog2(PH_MAX + 1);
  localparam int unsigned PCW    = $clog2(POLL_LIMIT + 1);

  localparam logic [PHW-1:0] SETUP_LOAD   = PHW'(SETUP_CYCLES - 1);
  localparam logic [PHW-1:0] EN_HIGH_LOAD = PHW'(EN_HIGH_CYCLES - 1);
  localparam logic [PHW-1:0] EN_LOW_LOAD  = PHW'(EN_LOW_CYCLES - 1);
  localparam logic [PCW-1:0] POLL_MAX     = PCW'(POLL_LIMIT);

  lcd_state_e state_q, state_d;

  logic           start_q;
  logic           armed_q;
  logic           rs_q, rs_d;
  logic           poll_q, poll_d;
  logic           done_q, done_d;
  logic           timeout_q, timeout_d;
  logic [7:0]     rd_q, rd_d;
  logic [PCW-1:0] pcnt_q, pcnt_d;
  logic           lcd_en_q, lcd_en_d;

  logic           accept;
  logic           tmr_load;
  logic [PHW-1:0] tmr_value;
  logic           tmr_expired;

  lcd_phase_timer #(
    .WIDTH (PHW)
  ) u_timer (
    .clock      (clock),
    .reset_n    (reset_n),
    .load       (tmr_load),
    .load_value (tmr_value),
    .expired    (tmr_expired)
  );

  // armed_q is low for the first cycle after reset, so a start level held
  // across reset release is absorbed into start_q rather than seen as an edge.
  assign accept = (state_q == ST_IDLE) && armed_q && start && !start_q;

  always_comb begin
    state_d   = state_q;
    rs_d      = rs_q;
    poll_d    = poll_q;
    done_d    = done_q;
    timeout_d = timeout_q;
    rd_d      = rd_q;
    pcnt_d    = pcnt_q;
    tmr_load  = 1'b0;
    tmr_value = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          poll_d    = poll;
          rs_d      = poll ? LCD_RS_CMD : rs;
          done_d    = 1'b0;
          timeout_d = 1'b0;
          pcnt_d    = '0;
          tmr_load  = 1'b1;
          tmr_value = SETUP_LOAD;
          state_d   = ST_SETUP;
        end
      end

      ST_SETUP: begin
        if (tmr_expired) begin
          tmr_load  = 1'b1;
          tmr_value = EN_HIGH_LOAD;
          state_d   = ST_EN_HIGH;
        end
      end

      ST_EN_HIGH: begin
        if (tmr_expired) begin
          // Sample on the edge where EN falls; pcnt counts pulses issued.
          rd_d = lcd_data_in;
          if (pcnt_q < POLL_MAX) begin
            pcnt_d = pcnt_q + 1'b1;
          end
          tmr_load  = 1'b1;
          tmr_value = EN_LOW_LOAD;
          state_d   = ST_EN_LOW;
        end
      end

      ST_EN_LOW: begin
        if (tmr_expired) begin
          if (poll_q && rd_q[LCD_BF_BIT] && (pcnt_q < POLL_MAX)) begin
            tmr_load  = 1'b1;
            tmr_value = SETUP_LOAD;
            state_d   = ST_SETUP;
          end else begin
            done_d    = 1'b1;
            timeout_d = poll_q && rd_q[LCD_BF_BIT];
            state_d   = ST_IDLE;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase

    lcd_en_d = (state_d == ST_EN_HIGH);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      start_q   <= 1'b0;
      armed_q   <= 1'b0;
      rs_q      <= LCD_RS_CMD;
      poll_q    <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      rd_q      <= '0;
      pcnt_q    <= '0;
      lcd_en_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      start_q   <= start;
      armed_q   <= 1'b1;
      rs_q      <= rs_d;
      poll_q    <= poll_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
      rd_q      <= rd_d;
      pcnt_q    <= pcnt_d;
      lcd_en_q  <= lcd_en_d;
    end
  end

  assign busy           = (state_q != ST_IDLE);
  assign lcd_bus_active = busy;
  assign lcd_rw         = busy ? LCD_RW_READ : LCD_RW_WRITE;
  assign lcd_rs         = busy ? rs_q : LCD_RS_CMD;
  assign lcd_en         = lcd_en_q;
  assign rd_data        = rd_q;
  assign done           = done_q;
  assign timeout        = timeout_q;

endmodule

// File: tb/tb_lcd_reader.sv
// Scoreboard bench for lcd_reader: stimulus pushes expected results, a
// negedge monitor pops and compares them whenever done rises.
module tb_lcd_reader;

  localparam int SETUP = 2;
  localparam int EH    = 16;
  localparam int EL    = 16;
  localparam int LIMIT = 4;
  localparam int P     = SETUP + EH + EL;

  typedef struct {
    logic [7:0] rd;
    bit         tmo;
    int         pulses;
    bit         rs;
  } exp_t;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       start, rs, poll;
  logic [7:0] rd_data;
  logic       done, timeout, busy;
  logic [7:0] lcd_data_in = 8'h00;
  logic       lcd_rw, lcd_en, lcd_rs, lcd_bus_active;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  exp_t       sb[$];
  logic [7:0] bus_q[$];
  logic [7:0] stim_bytes[$];

  int started   = 0;
  int completed = 0;

  lcd_reader #(
    .SETUP_CYCLES   (SETUP),
    .EN_HIGH_CYCLES (EH),
    .EN_LOW_CYCLES  (EL),
    .POLL_LIMIT     (LIMIT)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .start          (start),
    .rs             (rs),
    .poll           (poll),
    .rd_data        (rd_data),
    .done           (done),
    .timeout        (timeout),
    .busy           (busy),
    .lcd_data_in    (lcd_data_in),
    .lcd_rw         (lcd_rw),
    .lcd_en         (lcd_en),
    .lcd_rs         (lcd_rs),
    .lcd_bus_active (lcd_bus_active)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Bus model: present the current byte, advance after each EN pulse ends.
  logic bus_en_prev = 1'b0;
  always @(negedge clock) begin
    if (bus_en_prev && !lcd_en && bus_q.size() > 1) void'(bus_q.pop_front());
    lcd_data_in = (bus_q.size() > 0) ? bus_q[0] : 8'h00;
    bus_en_prev = lcd_en;
  end

  // Monitor
  logic en_prev = 0, busy_prev = 0, done_prev = 0, start_prev = 0;
  int   en_run = 0, pulses = 0, t_busy = 0, t_start = -1;
  logic rs_seen = 0, rs_bad = 0;

  always @(negedge clock) begin
    if (reset_n !== 1'b1) begin
      en_prev = 0; busy_prev = 0; done_prev = 0; start_prev = 0;
      en_run = 0; pulses = 0; t_start = -1; rs_bad = 0;
    end else begin
      if (lcd_en) en_run++;
      else if (en_prev) begin
        chk("en_high_width", en_run, EH);
        pulses++;
        en_run = 0;
      end
      if (start && !start_prev && !busy) t_start = cyc;
      if (busy && !busy_prev) begin
        started++;
        t_busy  = cyc;
        pulses  = 0;
        rs_seen = lcd_rs;
        rs_bad  = 0;
        if (t_start >= 0) chk("accept_latency", cyc - t_start, 1);
        t_start = -1;
      end
      if (busy && (lcd_rs !== rs_seen || lcd_rw !== 1'b1 ||
                   lcd_bus_active !== 1'b1 || done !== 1'b0)) rs_bad = 1;
      if (done && !done_prev) begin
        completed++;
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: got done with empty scoreboard (cycle %0d)", cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("rd_data", rd_data, e.rd);
          chk("timeout", timeout, e.tmo);
          chk("pulses", pulses, e.pulses);
          chk("txn_cycles", cyc - t_busy, e.pulses * P);
          chk("lcd_rs", rs_seen, e.rs);
          chk("ctrl_stable", rs_bad, 0);
          chk("idle_ctrl", {busy, lcd_rw, lcd_bus_active, lcd_en}, 0);
        end
      end
      en_prev = lcd_en; busy_prev = busy; done_prev = done; start_prev = start;
    end
  end

  // Reference model: derive the result from the byte sequence the bus presents.
  function automatic exp_t model(input bit rs_in, input bit poll_in);
    exp_t e;
    logic [7:0] b;
    if (!poll_in) begin
      e.rd = stim_bytes[0]; e.tmo = 0; e.pulses = 1; e.rs = rs_in;
    end else begin
      e.rs = 0; e.tmo = 1; e.pulses = LIMIT; e.rd = 8'h00;
      for (int i = 0; i < LIMIT; i++) begin
        b = (i < stim_bytes.size()) ? stim_bytes[i] : stim_bytes[stim_bytes.size()-1];
        e.rd = b;
        if (!b[7]) begin
          e.tmo = 0; e.pulses = i + 1;
          break;
        end
      end
    end
    return e;
  endfunction

  task automatic wait_idle(input string name, input int budget);
    bit ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      if (!busy && sb.size() == 0) begin ok = 1; break; end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL %s_wait: got no completion expected done within %0d cycles", name, budget);
      sb.delete();
    end
  endtask

  task automatic load_txn(input bit rs_in, input bit poll_in);
    sb.push_back(model(rs_in, poll_in));
    bus_q = stim_bytes;
  endtask

  task automatic pulse_start(input bit rs_in, input bit poll_in);
    @(posedge clock); #1;
    rs = rs_in; poll = poll_in; start = 1;
    @(posedge clock); #1;
    start = 0; rs = 1'($urandom); poll = 1'($urandom);
  endtask

  task automatic run_txn(input string name, input bit rs_in, input bit poll_in);
    load_txn(rs_in, poll_in);
    pulse_start(rs_in, poll_in);
    wait_idle(name, LIMIT * P + 50);
  endtask

  task automatic wait_en(output bit ok);
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (lcd_en) begin ok = 1; break; end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL wait_en: got lcd_en=0 expected 1 within 100 cycles");
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  initial begin
    int s0, c0, k;
    bit ok;
    reset_n = 0; start = 1; rs = 1; poll = 0;

    // Reset with start held high, then release with start still high.
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("reset_outputs", {rd_data, done, timeout, busy, lcd_en, lcd_rw, lcd_rs, lcd_bus_active}, 0);
    reset_n = 1;
    repeat (50) @(negedge clock);
    chk("no_start_after_reset", started, 0);
    chk("idle_after_reset", busy, 0);
    start = 0;
    repeat (2) @(negedge clock);

    // Single data read.
    stim_bytes = '{8'hA5};
    run_txn("single_read", 1, 0);

    // Poll that clears on the fourth pulse.
    stim_bytes = '{8'h80, 8'h80, 8'h80, 8'h0C};
    run_txn("poll_clear", 1, 1);

    // Poll that never clears.
    stim_bytes = '{8'h8F};
    run_txn("poll_timeout", 0, 1);

    // Second edge during EN high is ignored.
    s0 = started; c0 = completed;
    stim_bytes = '{8'h3C};
    load_txn(1, 0);
    pulse_start(1, 0);
    wait_en(ok);
    repeat (3) @(negedge clock);
    start = 1;
    @(negedge clock);
    start = 0;
    wait_idle("second_edge", 2 * P);
    repeat (P + 5) @(negedge clock);
    chk("second_edge_starts", started - s0, 1);
    chk("second_edge_dones", completed - c0, 1);

    // Start held high for 200 cycles.
    s0 = started; c0 = completed;
    stim_bytes = '{8'h5A};
    load_txn(0, 0);
    @(posedge clock); #1;
    rs = 0; poll = 0; start = 1;
    repeat (200) @(posedge clock);
    #1 start = 0;
    wait_idle("held_start", 2 * P);
    chk("held_start_starts", started - s0, 1);
    chk("held_start_dones", completed - c0, 1);

    // Reset in the fifth EN-high cycle aborts without done.
    c0 = completed;
    stim_bytes = '{8'hE7};
    bus_q = stim_bytes;
    pulse_start(1, 0);
    wait_en(ok);
    repeat (4) @(negedge clock);
    reset_n = 0;
    @(negedge clock);
    chk("midreset_ctrl", {lcd_en, lcd_rw, busy, lcd_bus_active, done}, 0);
    reset_n = 1;
    repeat (P + 5) @(negedge clock);
    chk("midreset_no_done", completed - c0, 0);
    chk("midreset_done_low", done, 0);
    stim_bytes = '{8'h42};
    run_txn("after_midreset", 1, 0);

    // Randomised mix of plain reads and polls.
    for (int t = 0; t < 12; t++) begin
      bit p, r;
      p = 1'($urandom);
      r = 1'($urandom);
      stim_bytes.delete();
      if (!p) begin
        stim_bytes.push_back(8'($urandom));
      end else begin
        k = $urandom_range(0, 6);
        for (int j = 0; j < k; j++) stim_bytes.push_back(8'h80 | 8'($urandom));
        stim_bytes.push_back(8'h7F & 8'($urandom));
      end
      run_txn("random", r, p);
      repeat ($urandom_range(0, 3)) @(negedge clock);
    end

    chk("scoreboard_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
